mem_bank_controller: RTL
========================

MEM_BANK_CONTROLLER -- requirements
Module: mem_bank_controller

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 16, number of load/store requesters.
REQ-002 SHALL have parameter NUM_CHANNELS, default 4, number of memory channels/banks; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_BITS, default 8, per-bank offset width.
REQ-004 SHALL have parameter DATA_BITS, default 8, data width.
REQ-005 SHALL define CH_BITS = log2(NUM_CHANNELS) and CADDR = ADDR_BITS + CH_BITS, the consumer address width.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
REQ-009 consumer_read_address  in  NUM_CONSUMERS*CADDR  flat vector; consumer c at [c*CADDR +: CADDR].
REQ-010 consumer_read_ready  out  NUM_CONSUMERS  read data valid to consumer.
REQ-011 consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  flat vector of read data.
REQ-012 consumer_write_valid / consumer_write_address / consumer_write_data  in  NUM_CONSUMERS / NUM_CONSUMERS*CADDR / NUM_CONSUMERS*DATA_BITS  write request.
REQ-013 consumer_write_ready  out  NUM_CONSUMERS  write completed.
REQ-014 mem_read_valid, mem_write_valid  out  NUM_CHANNELS  per-channel request to memory.
REQ-015 mem_read_address, mem_write_address  out  NUM_CHANNELS*ADDR_BITS  flat offset vectors.
REQ-016 mem_write_data  out  NUM_CHANNELS*DATA_BITS; mem_read_data  in  NUM_CHANNELS*DATA_BITS.
REQ-017 mem_read_ready, mem_write_ready  in  NUM_CHANNELS  memory completion, asserted one cycle after valid and held while valid stays high.

Function
REQ-018 Bank select SHALL be address[CADDR-1:ADDR_BITS]; offset SHALL be address[ADDR_BITS-1:0]; a request is served only by channel k equal to its bank select.
REQ-019 Each channel SHALL run an independent FSM: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
REQ-020 IDLE: scan consumers round-robin from rr_ptr[k], wrapping at NUM_CONSUMERS; first consumer with pending request to bank k not already being served is granted.
REQ-021 A consumer asserting read and write valid simultaneously SHALL get the read first; the write is served in a later grant.
REQ-022 On read grant: register mem_read_valid[k]=1 and offset, record consumer index, rr_ptr[k]=(c+1) mod NUM_CONSUMERS, go READ_WAIT; write grant likewise drives mem_write_valid, address, data, goes WRITE_WAIT.
REQ-023 READ_WAIT on mem_read_ready[k]: latch mem_read_data slice into consumer_read_data[c], set consumer_read_ready[c]=1, clear mem_read_valid[k], go RELAY; WRITE_WAIT analogous with consumer_write_ready[c].
REQ-024 RELAY: when the served consumer's valid is low, clear its ready, release the consumer, go IDLE; new grant no earlier than next cycle.
REQ-025 Latency SHALL be: consumer valid sampled in cycle 0 with idle channel -> mem valid cycle 1 -> mem ready cycle 2 -> consumer ready cycle 3.
REQ-026 Consumers SHALL hold valid, address, data stable until ready; ready held high until valid drops; controller need not tolerate changes mid-request.
REQ-027 Channels granting in the same cycle SHALL never share a consumer; different banks are served in parallel.
REQ-028 mem_read_ready/mem_write_ready SHALL be ignored in IDLE and RELAY.
REQ-029 consumer_read_data[c] SHALL retain last value after ready drops.

Reset
REQ-030 While reset is high at a clock edge: all outputs zero, all FSMs IDLE, all rr_ptr zero, all served flags cleared; in-flight requests abandoned, no ready issued for them.

Verification
REQ-031 Consumer 0 reads address 0x105 (4 banks, bank 1, offset 0x05), memory returns 0xA7 -> mem_read_valid[1] with offset 0x05 cycle 1; consumer_read_ready[0]=1, data 0xA7 cycle 3.
REQ-032 Consumers 2 and 5 both read bank 0, rr_ptr 0 -> consumer 2 served first, consumer 5 granted after 2 drops valid; next contest of 2 and 5 grants 5.
REQ-033 Consumer 1 reads bank 0, consumer 3 writes 0x3C to bank 2 same cycle -> both mem valids rise cycle 1, both readies cycle 3.
REQ-034 Consumer 4 asserts read and write valid to bank 3 -> read completes first, write granted only after read RELAY exits.
REQ-035 Reset asserted in READ_WAIT -> next cycle all mem valids and consumer readies 0; re-issued request completes with normal 3-cycle latency.

Source files
------------

// File: rtl/mem_bank_controller.sv
// Banked memory front end: consumers address one flat space; the upper address bits pick a
// channel, and each channel arbitrates round-robin among its consumers and relays one access at a time.
module mem_bank_controller #(
    parameter int NUM_CONSUMERS = 16,
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    localparam int CH_BITS      = $clog2(NUM_CHANNELS),
    localparam int CADDR        = ADDR_BITS + CH_BITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*CADDR-1:0]     consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*CADDR-1:0]     consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
    output logic [2*NUM_CHANNELS-1:0]          channel_state
);

    // Handshake: a request stays valid (address/data stable) until its ready is seen;
    // ready then stays high until the requester drops valid, after which the slot is released.
    localparam int CON_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } state_t;

    state_t                state      [NUM_CHANNELS];
    state_t                state_next [NUM_CHANNELS];
    logic [CON_BITS-1:0]   rr_ptr     [NUM_CHANNELS];
    logic [CON_BITS-1:0]   owner      [NUM_CHANNELS];
    logic [CON_BITS-1:0]   grant_idx  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  owner_write;
    logic [NUM_CHANNELS-1:0]  grant_valid;
    logic [NUM_CHANNELS-1:0]  grant_write;
    logic [NUM_CHANNELS-1:0]  relay_done;
    logic [NUM_CONSUMERS-1:0] served;
    logic [NUM_CONSUMERS-1:0] taken;
    logic [CH_BITS-1:0]    rd_bank [NUM_CONSUMERS];
    logic [CH_BITS-1:0]    wr_bank [NUM_CONSUMERS];
    int                    scan_idx;
    logic [CON_BITS-1:0]   cand;

    for (genvar c = 0; c < NUM_CONSUMERS; c++) begin : g_bank
        assign rd_bank[c] = consumer_read_address[c*CADDR+ADDR_BITS +: CH_BITS];
        assign wr_bank[c] = consumer_write_address[c*CADDR+ADDR_BITS +: CH_BITS];
    end

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_state
        assign channel_state[2*k +: 2] = state[k];
    end

    // Channels are resolved in index order; 'taken' stops two channels granting one consumer
    // in the same cycle, 'served' stops a consumer being granted while another access is open.
    always_comb begin
        taken       = '0;
        grant_valid = '0;
        grant_write = '0;
        relay_done  = '0;
        scan_idx    = 0;
        cand        = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            grant_idx[k]  = '0;
            state_next[k] = state[k];
        end
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                scan_idx = int'(rr_ptr[k]) + i;
                if (scan_idx >= NUM_CONSUMERS) scan_idx = scan_idx - NUM_CONSUMERS;
                cand = CON_BITS'(scan_idx);
                if (state[k] == IDLE && !grant_valid[k] && !served[cand] && !taken[cand]) begin
                    if (consumer_read_valid[cand] && rd_bank[cand] == CH_BITS'(k)) begin
                        grant_valid[k] = 1'b1;
                        grant_idx[k]   = cand;
                    end else if (consumer_write_valid[cand] && !consumer_read_valid[cand] &&
                                 wr_bank[cand] == CH_BITS'(k)) begin
                        grant_valid[k] = 1'b1;
                        grant_write[k] = 1'b1;
                        grant_idx[k]   = cand;
                    end
                end
            end
            if (grant_valid[k]) taken[grant_idx[k]] = 1'b1;
            relay_done[k] = owner_write[k] ? !consumer_write_valid[owner[k]]
                                           : !consumer_read_valid[owner[k]];
            case (state[k])
                IDLE:       if (grant_valid[k]) state_next[k] = grant_write[k] ? WRITE_WAIT : READ_WAIT;
                READ_WAIT:  if (mem_read_ready[k]) state_next[k] = RELAY;
                WRITE_WAIT: if (mem_write_ready[k]) state_next[k] = RELAY;
                RELAY:      if (relay_done[k]) state_next[k] = IDLE;
                default:    state_next[k] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (reset) state[k] <= IDLE;
            else       state[k] <= state_next[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                rr_ptr[k] <= '0;
                owner[k]  <= '0;
            end
            owner_write          <= '0;
            served               <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                case (state[k])
                    IDLE: if (grant_valid[k]) begin
                        owner[k]               <= grant_idx[k];
                        owner_write[k]         <= grant_write[k];
                        served[grant_idx[k]]   <= 1'b1;
                        rr_ptr[k] <= (grant_idx[k] == CON_BITS'(NUM_CONSUMERS-1)) ? '0
                                                                                  : grant_idx[k] + 1'b1;
                        if (grant_write[k]) begin
                            mem_write_valid[k] <= 1'b1;
                            mem_write_address[k*ADDR_BITS +: ADDR_BITS] <=
                                consumer_write_address[grant_idx[k]*CADDR +: ADDR_BITS];
                            mem_write_data[k*DATA_BITS +: DATA_BITS] <=
                                consumer_write_data[grant_idx[k]*DATA_BITS +: DATA_BITS];
                        end else begin
                            mem_read_valid[k] <= 1'b1;
                            mem_read_address[k*ADDR_BITS +: ADDR_BITS] <=
                                consumer_read_address[grant_idx[k]*CADDR +: ADDR_BITS];
                        end
                    end
                    READ_WAIT: if (mem_read_ready[k]) begin
                        consumer_read_data[owner[k]*DATA_BITS +: DATA_BITS] <=
                            mem_read_data[k*DATA_BITS +: DATA_BITS];
                        consumer_read_ready[owner[k]] <= 1'b1;
                        mem_read_valid[k]             <= 1'b0;
                    end
                    WRITE_WAIT: if (mem_write_ready[k]) begin
                        consumer_write_ready[owner[k]] <= 1'b1;
                        mem_write_valid[k]             <= 1'b0;
                    end
                    RELAY: if (relay_done[k]) begin
                        if (owner_write[k]) consumer_write_ready[owner[k]] <= 1'b0;
                        else                consumer_read_ready[owner[k]]  <= 1'b0;
                        served[owner[k]] <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
